// File: rtl/wish_unpack_var.sv
// Wishbone wide-beat to word-stream unpacker with a two-slot ping-pong buffer and per-beat word count.
// Optional WISH_UNPACK_VAR_ERR_EN: out-of-range counts are dropped and flagged on a sticky err_o.
module wish_unpack_var #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int LITTLE_ENDIAN = 1,
    localparam int CNT_W        = $clog2(NUM_PACK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
`ifdef WISH_UNPACK_VAR_ERR_EN
    output logic                           err_o,
`endif
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [CNT_W-1:0]               s_cnt_i,
    input  logic [1:0]                     s_tgc_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [1:0]                     d_tgc_o
);

    typedef struct packed {
        logic [DATA_WIDTH*NUM_PACK-1:0] dat;
        logic [CNT_W-1:0]               len;
        logic [1:0]                     tgc;
    } slot_t;

    slot_t                                slot_q [2];
    slot_t                                rd_slot;
    logic                                 wr_ptr_q, rd_ptr_q;
    logic [1:0]                           occ_q;
    logic [CNT_W-1:0]                     idx_q;
    logic                                 cnt_ok, push, pop, last;
    logic [CNT_W-1:0]                     len_in;
    logic [NUM_PACK-1:0][DATA_WIDTH-1:0] words;
    logic [DATA_WIDTH-1:0]                cur;

    assign cnt_ok  = (s_cnt_i != '0) && (s_cnt_i <= CNT_W'(NUM_PACK));
    assign s_ack_o = rst_n_i & s_stb_i & s_cyc_i & (occ_q != 2'd2);
    assign s_stall_o = (occ_q == 2'd2);

`ifdef WISH_UNPACK_VAR_ERR_EN
    // Bad beats are still acked so the source never deadlocks, but nothing is stored.
    assign push   = s_ack_o & cnt_ok;
    assign len_in = s_cnt_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_o <= 1'b0;
        else if (s_ack_o && !cnt_ok) err_o <= 1'b1;
    end
`else
    assign push   = s_ack_o;
    assign len_in = cnt_ok ? s_cnt_i : CNT_W'(NUM_PACK);
`endif

    assign rd_slot = slot_q[rd_ptr_q];
    assign d_stb_o = (occ_q != 2'd0);
    assign d_cyc_o = d_stb_o;
    assign last    = (idx_q == rd_slot.len - CNT_W'(1));
    assign pop     = d_stb_o & d_ack_i & last;

    for (genvar g = 0; g < NUM_PACK; g++) begin : g_word
        if (LITTLE_ENDIAN != 0) begin : g_le
            assign words[g] = rd_slot.dat[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_be
            assign words[g] = rd_slot.dat[(NUM_PACK-1-g)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_PACK; i++)
            if (idx_q == CNT_W'(i)) cur = words[i];
    end

    assign d_dat_o    = d_stb_o ? cur : '0;
    assign d_tgc_o[0] = d_stb_o & rd_slot.tgc[0] & (idx_q == '0);
    assign d_tgc_o[1] = d_stb_o & rd_slot.tgc[1] & last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
        end else if (push) begin
            slot_q[wr_ptr_q] <= '{dat: s_dat_i, len: len_in, tgc: s_tgc_i};
            wr_ptr_q         <= ~wr_ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
        end else if (d_stb_o && d_ack_i) begin
            if (last) begin
                idx_q    <= '0;
                rd_ptr_q <= ~rd_ptr_q;
            end else begin
                idx_q <= idx_q + CNT_W'(1);
            end
        end
    end

    // A simultaneous push and pop only happens at occupancy 1, so holding is correct.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) occ_q <= 2'd0;
        else begin
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule
